// File: rtl/can_tx_pkg.sv
// Shared types and constants for the CAN frame transmitter: state encoding, CRC polynomial,
// fixed field lengths and the state-region helpers used by the sequencer.
package can_tx_pkg;

  localparam logic [14:0] CRC_POLY = 15'h4599;

  localparam int unsigned ID_LEN  = 11;
  localparam int unsigned IDX_LEN = 18;
  localparam int unsigned DLC_LEN = 4;
  localparam int unsigned CRC_LEN = 15;
  localparam int unsigned EOF_LEN = 7;

  // ST_START holds the accepted request until the first bit_tick drives SOF.
  typedef enum logic [4:0] {
    ST_IDLE,
    ST_START,
    ST_SOF,
    ST_ID,
    ST_SRR_RTR,
    ST_IDE,
    ST_IDX,
    ST_RTR_E,
    ST_R1,
    ST_R0,
    ST_DLC,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK,
    ST_ACK_DEL,
    ST_EOF,
    ST_IFS
  } tx_state_e;

  function automatic logic in_crc_region(input tx_state_e s);
    logic r;
    r = 1'b0;
    case (s)
      ST_SOF, ST_ID, ST_SRR_RTR, ST_IDE, ST_IDX,
      ST_RTR_E, ST_R1, ST_R0, ST_DLC, ST_DATA: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic in_stuff_region(input tx_state_e s);
    return in_crc_region(s) || (s == ST_CRC);
  endfunction

  function automatic logic in_arb_region(input tx_state_e s, input logic ide);
    logic r;
    r = 1'b0;
    case (s)
      ST_ID, ST_SRR_RTR:        r = 1'b1;
      ST_IDE, ST_IDX, ST_RTR_E: r = ide;
      default:                  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/can_frame_tx_if.sv
// Host/bus-side signal bundle of the CAN frame transmitter; master drives requests and rx,
// slave is the transmitter itself.
interface can_frame_tx_if;
  logic        bit_tick;
  logic        start;
  logic        ide;
  logic        rtr;
  logic [10:0] id;
  logic [17:0] id_ext;
  logic [3:0]  dlc;
  logic [63:0] data;
  logic        rx;
  logic        tx;
  logic        busy;
  logic        done;
  logic        ack_err;
  logic        arb_lost;

  modport master (
    output bit_tick, start, ide, rtr, id, id_ext, dlc, data, rx,
    input  tx, busy, done, ack_err, arb_lost
  );

  modport slave (
    input  bit_tick, start, ide, rtr, id, id_ext, dlc, data, rx,
    output tx, busy, done, ack_err, arb_lost
  );
endinterface

// File: rtl/can_crc15_ser.sv
// Serial CAN CRC-15 accumulator: one unstuffed bit per en, MSB-first shift, init zero.
module can_crc15_ser
  import can_tx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [14:0] crc
);

  logic [14:0] r_crc;
  logic        w_fb;

  assign w_fb = din ^ r_crc[14];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_crc <= '0;
    end else if (en) begin
      r_crc <= {r_crc[13:0], 1'b0} ^ (w_fb ? CRC_POLY : 15'h0000);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/can_frame_tx.sv
// can_frame_tx: serialises one classical CAN 2.0 frame (base/extended, data/remote) with
// bit stuffing and CRC-15. Define CAN_TX_ARB_EN to enable arbitration-loss detection.
module can_frame_tx
  import can_tx_pkg::*;
#(
  parameter int unsigned STUFF_LEN = 5,
  parameter int unsigned IFS_BITS  = 3
) (
  input logic           clk,
  input logic           reset,
  can_frame_tx_if.slave bus
);

  localparam int unsigned      RUN_W   = $clog2(STUFF_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);

  tx_state_e        r_state;
  logic [6:0]       r_cnt;
  logic [RUN_W-1:0] r_run;
  logic             r_last;
  logic             r_stuff;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
  logic             r_ack_err;
  logic             r_arb_lost;

  logic             r_ide;
  logic             r_rtr;
  logic [10:0]      r_id;
  logic [17:0]      r_idx;
  logic [3:0]       r_dlc;
  logic [63:0]      r_data;
  logic [6:0]       r_data_bits;

  logic [6:0]       w_field_len;
  logic             w_field_end;
  tx_state_e        w_adv_state;
  logic [6:0]       w_adv_cnt;
  logic             w_adv_bit;
  logic [3:0]       w_idx_id;
  logic [4:0]       w_idx_x;
  logic [1:0]       w_idx_dlc;
  logic [5:0]       w_idx_data;
  logic [3:0]       w_idx_crc;
  logic             w_stuff_now;
  logic             w_accept;
  logic             w_crc_en;
  logic [14:0]      w_crc;
  logic             w_arb_fail;

  // Field sequencing: where the next non-stuff bit comes from and what value it carries.
  always_comb begin
    w_field_len = 7'd1;
    case (r_state)
      ST_ID:   w_field_len = 7'(ID_LEN);
      ST_IDX:  w_field_len = 7'(IDX_LEN);
      ST_DLC:  w_field_len = 7'(DLC_LEN);
      ST_DATA: w_field_len = r_data_bits;
      ST_CRC:  w_field_len = 7'(CRC_LEN);
      ST_EOF:  w_field_len = 7'(EOF_LEN);
      ST_IFS:  w_field_len = 7'(IFS_BITS);
      default: w_field_len = 7'd1;
    endcase
    w_field_end = (r_cnt == (w_field_len - 7'd1));

    w_adv_state = r_state;
    w_adv_cnt   = r_cnt + 7'd1;
    if (w_field_end) begin
      w_adv_cnt = '0;
      case (r_state)
        ST_START:   w_adv_state = ST_SOF;
        ST_SOF:     w_adv_state = ST_ID;
        ST_ID:      w_adv_state = ST_SRR_RTR;
        ST_SRR_RTR: w_adv_state = ST_IDE;
        ST_IDE:     w_adv_state = r_ide ? ST_IDX : ST_R0;
        ST_IDX:     w_adv_state = ST_RTR_E;
        ST_RTR_E:   w_adv_state = ST_R1;
        ST_R1:      w_adv_state = ST_R0;
        ST_R0:      w_adv_state = ST_DLC;
        ST_DLC:     w_adv_state = (r_rtr || (r_data_bits == 7'd0)) ? ST_CRC : ST_DATA;
        ST_DATA:    w_adv_state = ST_CRC;
        ST_CRC:     w_adv_state = ST_CRC_DEL;
        ST_CRC_DEL: w_adv_state = ST_ACK;
        ST_ACK:     w_adv_state = ST_ACK_DEL;
        ST_ACK_DEL: w_adv_state = ST_EOF;
        ST_EOF:     w_adv_state = ST_IFS;
        default:    w_adv_state = ST_IDLE;
      endcase
    end

    w_idx_id   = 4'd10 - w_adv_cnt[3:0];
    w_idx_x    = 5'd17 - w_adv_cnt[4:0];
    w_idx_dlc  = 2'd3 - w_adv_cnt[1:0];
    w_idx_data = 6'd63 - w_adv_cnt[5:0];
    w_idx_crc  = 4'd14 - w_adv_cnt[3:0];

    w_adv_bit = 1'b1;
    case (w_adv_state)
      ST_SOF:       w_adv_bit = 1'b0;
      ST_ID:        w_adv_bit = r_id[w_idx_id];
      ST_SRR_RTR:   w_adv_bit = r_ide ? 1'b1 : r_rtr;
      ST_IDE:       w_adv_bit = r_ide;
      ST_IDX:       w_adv_bit = r_idx[w_idx_x];
      ST_RTR_E:     w_adv_bit = r_rtr;
      ST_R1, ST_R0: w_adv_bit = 1'b0;
      ST_DLC:       w_adv_bit = r_dlc[w_idx_dlc];
      ST_DATA:      w_adv_bit = r_data[w_idx_data];
      ST_CRC:       w_adv_bit = w_crc[w_idx_crc];
      default:      w_adv_bit = 1'b1;
    endcase
  end

  // The stuff check also fires after the final CRC bit, so a run ending the CRC is still broken.
  assign w_stuff_now = in_stuff_region(r_state) && (r_run == RUN_MAX);
  assign w_accept    = bus.start && (r_state == ST_IDLE);
  assign w_crc_en    = bus.bit_tick && (r_state != ST_IDLE) && !w_stuff_now
                       && in_crc_region(w_adv_state);

`ifdef CAN_TX_ARB_EN
  assign w_arb_fail = bus.bit_tick && (r_state != ST_IDLE) && !r_stuff
                      && in_arb_region(r_state, r_ide) && r_tx && !bus.rx;
`else
  assign w_arb_fail = 1'b0;
`endif

  can_crc15_ser u_crc (
    .clk   (clk),
    .reset (reset),
    .clear (w_accept),
    .en    (w_crc_en),
    .din   (w_adv_bit),
    .crc   (w_crc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_run       <= '0;
      r_last      <= 1'b1;
      r_stuff     <= 1'b0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ack_err   <= 1'b0;
      r_arb_lost  <= 1'b0;
      r_ide       <= 1'b0;
      r_rtr       <= 1'b0;
      r_id        <= '0;
      r_idx       <= '0;
      r_dlc       <= '0;
      r_data      <= '0;
      r_data_bits <= '0;
    end else begin
      r_done     <= 1'b0;
      r_ack_err  <= 1'b0;
      r_arb_lost <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (bus.start) begin
          r_ide       <= bus.ide;
          r_rtr       <= bus.rtr;
          r_id        <= bus.id;
          r_idx       <= bus.id_ext;
          r_dlc       <= bus.dlc;
          r_data      <= bus.data;
          r_data_bits <= (bus.dlc > 4'd8) ? 7'd64 : {bus.dlc, 3'b000};
          r_state     <= ST_START;
          r_cnt       <= '0;
          r_run       <= '0;
          r_last      <= 1'b1;
          r_stuff     <= 1'b0;
          r_busy      <= 1'b1;
        end
      end else if (bus.bit_tick) begin
        if ((r_state == ST_ACK) && !r_stuff && bus.rx) begin
          r_ack_err <= 1'b1;
        end
        if (w_arb_fail) begin
          r_arb_lost <= 1'b1;
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_tx       <= 1'b1;
          r_stuff    <= 1'b0;
        end else if (w_stuff_now) begin
          r_tx    <= ~r_last;
          r_last  <= ~r_last;
          r_run   <= RUN_ONE;
          r_stuff <= 1'b1;
        end else if ((r_state == ST_IFS) && w_field_end) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_tx    <= 1'b1;
          r_stuff <= 1'b0;
        end else begin
          r_state <= w_adv_state;
          r_cnt   <= w_adv_cnt;
          r_tx    <= w_adv_bit;
          r_last  <= w_adv_bit;
          r_stuff <= 1'b0;
          if (in_stuff_region(w_adv_state)) begin
            r_run <= (w_adv_bit == r_last) ? r_run + RUN_ONE : RUN_ONE;
          end else begin
            r_run <= '0;
          end
        end
      end
    end
  end

  assign bus.tx       = r_tx;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.ack_err  = r_ack_err;
  assign bus.arb_lost = r_arb_lost;

endmodule

// File: tb/tb_can_frame_tx.sv
// Self-checking bench for can_frame_tx: each frame is rebuilt from the field rules as a bit
// queue (CRC, stuffing, tail) and the serial output is compared bit by bit.
module tb_can_frame_tx;

  logic clk = 1'b0;
  logic reset;

  can_frame_tx_if bus ();

  can_frame_tx #(.STUFF_LEN(5), .IFS_BITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  logic exp_q[$];
  int   pos_map[$];
  int   ack_pos;
  logic s_done, s_ack, s_arb, s_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: unstuffed fields, CRC over SOF..data, stuffing through CRC, fixed tail.
  task automatic build(input logic ide, input logic rtr, input logic [10:0] id,
                       input logic [17:0] idx, input logic [3:0] dlc, input logic [63:0] data);
    logic        u[$];
    logic [14:0] crc;
    logic        fb, last;
    int          nbytes, run;
    u = {};
    u.push_back(1'b0);
    for (int i = 10; i >= 0; i--) u.push_back(id[i]);
    if (!ide) begin
      u.push_back(rtr); u.push_back(1'b0); u.push_back(1'b0);
    end else begin
      u.push_back(1'b1); u.push_back(1'b1);
      for (int i = 17; i >= 0; i--) u.push_back(idx[i]);
      u.push_back(rtr); u.push_back(1'b0); u.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) u.push_back(dlc[i]);
    nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < nbytes * 8; i++) u.push_back(data[63 - i]);
    crc = '0;
    foreach (u[i]) begin
      fb  = u[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (fb) crc = crc ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) u.push_back(crc[i]);
    exp_q = {}; pos_map = {}; run = 0; last = 1'b1;
    foreach (u[i]) begin
      pos_map.push_back(exp_q.size());
      exp_q.push_back(u[i]);
      if (u[i] == last) run++; else begin run = 1; last = u[i]; end
      if (run == 5) begin exp_q.push_back(!last); last = !last; run = 1; end
    end
    exp_q.push_back(1'b1);
    ack_pos = exp_q.size();
    repeat (1 + 1 + 7 + 3) exp_q.push_back(1'b1);
  endtask

  task automatic tick();
    @(negedge clk) bus.bit_tick = 1'b1;
    @(negedge clk) bus.bit_tick = 1'b0;
    s_done = bus.done; s_ack = bus.ack_err; s_arb = bus.arb_lost; s_busy = bus.busy;
    @(negedge clk);
  endtask

  task automatic send(input string nm, input logic ide, input logic rtr, input logic [10:0] id,
                      input logic [17:0] idx, input logic [3:0] dlc, input logic [63:0] data,
                      input logic ack_rx, input bit rx_all1, input int arb_u, input int abort_u,
                      input bit poke);
    int  n_done, n_ack, arb_pos, abort_pos;
    bit  stop_arb, stop_rst;
    n_done = 0; n_ack = 0; stop_arb = 0; stop_rst = 0;
    build(ide, rtr, id, idx, dlc, data);
    arb_pos   = (arb_u >= 0) ? pos_map[arb_u] : -1;
    abort_pos = (abort_u >= 0) ? pos_map[abort_u] : -1;
    @(negedge clk);
    bus.ide = ide; bus.rtr = rtr; bus.id = id; bus.id_ext = idx;
    bus.dlc = dlc; bus.data = data; bus.start = 1'b1; bus.rx = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    chk({nm, ".busy_at_start"}, bus.busy, 1);
    chk({nm, ".tx_before_sof"}, bus.tx, 1);
    for (int k = 0; k <= exp_q.size() && !stop_arb && !stop_rst; k++) begin
      if (rx_all1 || k == 0)   bus.rx = 1'b1;
      else if (k - 1 == ack_pos) bus.rx = ack_rx;
      else if (k - 1 == arb_pos) bus.rx = 1'b0;
      else                      bus.rx = exp_q[k - 1];
      if (poke && k == 3) begin
        bus.start = 1'b1; bus.id = 11'($urandom); bus.dlc = 4'($urandom);
        bus.data = {$urandom, $urandom}; bus.ide = ~ide;
      end
      tick();
      bus.start = 1'b0;
      n_done += int'(s_done);
      n_ack  += int'(s_ack);
`ifdef CAN_TX_ARB_EN
      if (k - 1 == arb_pos) begin
        chk({nm, ".arb_lost"}, s_arb, 1);
        chk({nm, ".arb_busy"}, s_busy, 0);
        chk({nm, ".arb_tx"}, bus.tx, 1);
        stop_arb = 1;
      end else
`endif
      begin
        chk($sformatf("%s.arb_quiet[%0d]", nm, k), s_arb, 0);
        if (k < exp_q.size()) begin
          chk($sformatf("%s.tx[%0d]", nm, k), bus.tx, exp_q[k]);
          chk($sformatf("%s.busy[%0d]", nm, k), s_busy, 1);
        end else begin
          chk({nm, ".done_pulse"}, s_done, 1);
          chk({nm, ".busy_drop"}, s_busy, 0);
        end
        if (k == ack_pos + 1) chk({nm, ".ack_err_slot"}, s_ack, ack_rx | rx_all1);
      end
      if (k == abort_pos) begin
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk({nm, ".abort_tx"}, bus.tx, 1);
        chk({nm, ".abort_busy"}, bus.busy, 0);
        reset = 1'b0;
        bus.rx = 1'b1;
        tick();
        chk({nm, ".abort_no_done"}, s_done, 0);
        chk({nm, ".abort_idle_tx"}, bus.tx, 1);
        stop_rst = 1;
      end
    end
    if (stop_arb) begin
      bus.rx = 1'b1;
      for (int j = 0; j < 3; j++) begin
        tick();
        chk({nm, ".post_arb_tx"}, bus.tx, 1);
        chk({nm, ".post_arb_done"}, s_done, 0);
        chk({nm, ".post_arb_busy"}, s_busy, 0);
      end
    end else if (!stop_rst) begin
      chk({nm, ".done_count"}, n_done, 1);
      chk({nm, ".ack_err_count"}, n_ack, (ack_rx | rx_all1) ? 1 : 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] rid;
    logic [17:0] rx_id;
    logic [63:0] rdata;
    bus.bit_tick = 1'b0; bus.start = 1'b0; bus.ide = 1'b0; bus.rtr = 1'b0;
    bus.id = '0; bus.id_ext = '0; bus.dlc = '0; bus.data = '0; bus.rx = 1'b1;

    // reset and start together: reset wins
    reset = 1'b1;
    bus.start = 1'b1; bus.id = 11'h555; bus.dlc = 4'd2;
    @(negedge clk);
    @(negedge clk);
    chk("rst.tx", bus.tx, 1);
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.ack_err", bus.ack_err, 0);
    chk("rst.arb_lost", bus.arb_lost, 0);
    reset = 1'b0; bus.start = 1'b0;
    tick();
    chk("rst.idle_tx", bus.tx, 1);
    chk("rst.idle_busy", s_busy, 0);

    send("base_a5", 1'b0, 1'b0, 11'h123, 18'h0, 4'd1, 64'hA500_0000_0000_0000,
         1'b0, 0, -1, -1, 0);
    send("ext_rtr", 1'b1, 1'b1, 11'h7FF, 18'h3FFFF, 4'hA, 64'($urandom),
         1'b0, 0, -1, -1, 0);
    send("zero_id", 1'b0, 1'b0, 11'h000, 18'h0, 4'd0, 64'h0, 1'b0, 0, -1, -1, 0);
    send("no_ack", 1'b0, 1'b0, 11'h2A5, 18'h0, 4'd2, {$urandom, $urandom},
         1'b1, 1, -1, -1, 0);
    send("arb_bit3", 1'b0, 1'b0, 11'h0F0, 18'h0, 4'd2, {$urandom, $urandom},
         1'b0, 0, 4, -1, 0);
    send("abort_d20", 1'b0, 1'b0, 11'h3C1, 18'h0, 4'd8, {$urandom, $urandom},
         1'b0, 0, -1, 39, 0);
    send("after_abort", 1'b0, 1'b0, 11'h3C1, 18'h0, 4'd8, {$urandom, $urandom},
         1'b0, 0, -1, -1, 0);

    for (int f = 0; f < 6; f++) begin
      rid = 11'($urandom); rx_id = 18'($urandom); rdata = {$urandom, $urandom};
      send($sformatf("rand%0d", f), 1'($urandom), 1'($urandom_range(0, 3) == 0), rid, rx_id,
           4'($urandom), rdata, 1'b0, 0, -1, -1, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
